cache_block_transfer_responder: RTL and testbench

- Memory-side end of the cache miss/writeback handshake. Answers the cache controller's block requests (`req/rw/write/read/ready_*`).
- Holds a 16-word writeback FIFO (cache→memory) and a 16-word fill FIFO (memory→cache).
- Drives a word-serial request/acknowledge port toward external memory.
- Sits between one cache instance and the external memory arbiter.

---
 rtl/cache_block_transfer_responder.sv | 274 +++++++++++++++++++++++++++
 tb/tb_cache_block_transfer_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_block_transfer_responder.sv
// Memory-side block responder for one cache: request slots, writeback and
// fill FIFOs, and a word-serial req/ack port toward external memory.
//
// Ports (clock_i, reset_i synchronous active-low):
//   cache side : req_i req_block_i rw_i add_i write_i data_i read_i
//                ready_req_o ready_write_o ready_read_o data_o err_o
//   memory side: mem_req_o mem_rw_o mem_add_o mem_data_o mem_ack_i mem_data_i
//   optional   : comm_i comm_o (BLOCK_RESPONDER_PERF_EN)
//
// Optional feature macro: BLOCK_RESPONDER_PERF_EN adds 64-bit fetch, flush
// and memory-stall counters readable through comm_i/comm_o.
module cache_block_transfer_responder #(
  parameter int BW_ADDR  = 24,
  parameter int BW_BLOCK = 4
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               req_i,
  input  logic               req_block_i,
  input  logic               rw_i,
  input  logic [BW_ADDR-1:0] add_i,
  input  logic               write_i,
  input  logic [31:0]        data_i,
  input  logic               read_i,
  output logic               ready_req_o,
  output logic               ready_write_o,
  output logic               ready_read_o,
  output logic [31:0]        data_o,
  output logic               err_o,
  output logic               mem_req_o,
  output logic               mem_rw_o,
  output logic [BW_ADDR-1:0] mem_add_o,
  output logic [31:0]        mem_data_o,
  input  logic               mem_ack_i,
  input  logic [31:0]        mem_data_i
`ifdef BLOCK_RESPONDER_PERF_EN
  ,
  input  logic [31:0]        comm_i,
  output logic [31:0]        comm_o
`endif
);

  localparam int DEPTH = 1 << BW_BLOCK;
  localparam int CW    = BW_BLOCK + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                rd_valid_q, rd_valid_d;
  logic [BW_ADDR-1:0]  rd_addr_q, rd_addr_d;
  logic                wb_valid_q, wb_valid_d;
  logic [BW_ADDR-1:0]  wb_addr_q, wb_addr_d;
  logic                ready_req_q, ready_req_d;
  logic                err_q, err_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_rw_q, mem_rw_d;
  logic [BW_ADDR-1:0]  mem_add_q, mem_add_d;
  logic [31:0]         mem_data_q, mem_data_d;
  logic [BW_BLOCK-1:0] n_q, n_d;

  logic [CW-1:0]       wb_cnt_q, wb_cnt_d;
  logic [BW_BLOCK-1:0] wb_wptr_q, wb_wptr_d;
  logic [BW_BLOCK-1:0] wb_rptr_q, wb_rptr_d;
  logic [CW-1:0]       fill_cnt_q, fill_cnt_d;
  logic [BW_BLOCK-1:0] fill_wptr_q, fill_wptr_d;
  logic [BW_BLOCK-1:0] fill_rptr_q, fill_rptr_d;

  logic [31:0] wb_mem_q   [DEPTH];
  logic [31:0] fill_mem_q [DEPTH];

  logic req_ok, req_bad;
  logic wb_full, wb_push, wb_bad, wb_pop;
  logic fill_empty, fill_full, fill_push, fill_pop, fill_bad;
  logic mem_done, last;

  // Word address inside the block; the offset wraps, never carrying upward.
  function automatic logic [BW_ADDR-1:0] blk_add(
    input logic [BW_ADDR-1:0]  base,
    input logic [BW_BLOCK-1:0] idx
  );
    blk_add = {base[BW_ADDR-1:BW_BLOCK], base[BW_BLOCK-1:0] + idx};
  endfunction

  assign req_ok     = req_i & ready_req_q & req_block_i;
  assign req_bad    = req_i & (~ready_req_q | ~req_block_i);
  assign wb_full    = wb_cnt_q == FULL;
  assign wb_push    = write_i & ~wb_full;
  assign wb_bad     = write_i & wb_full;
  assign fill_empty = fill_cnt_q == '0;
  assign fill_full  = fill_cnt_q == FULL;
  assign fill_pop   = read_i & ~fill_empty;
  assign fill_bad   = read_i & fill_empty;
  assign mem_done   = mem_req_q & mem_ack_i;
  assign fill_push  = mem_done & (state_q == S_FETCH);
  assign wb_pop     = mem_done & (state_q == S_FLUSH);
  assign last       = n_q == '1;

  always_comb begin
    state_d     = state_q;
    rd_valid_d  = rd_valid_q;
    rd_addr_d   = rd_addr_q;
    wb_valid_d  = wb_valid_q;
    wb_addr_d   = wb_addr_q;
    mem_req_d   = mem_req_q;
    mem_rw_d    = mem_rw_q;
    mem_add_d   = mem_add_q;
    mem_data_d  = mem_data_q;
    n_d         = n_q;
    err_d       = err_q | req_bad | wb_bad | fill_bad;

    wb_wptr_d   = wb_wptr_q + BW_BLOCK'(wb_push);
    wb_rptr_d   = wb_rptr_q + BW_BLOCK'(wb_pop);
    wb_cnt_d    = wb_cnt_q + CW'(wb_push) - CW'(wb_pop);
    fill_wptr_d = fill_wptr_q + BW_BLOCK'(fill_push);
    fill_rptr_d = fill_rptr_q + BW_BLOCK'(fill_pop);
    fill_cnt_d  = fill_cnt_q + CW'(fill_push) - CW'(fill_pop);

    if (req_ok) begin
      if (rw_i) begin
        wb_valid_d = 1'b1;
        wb_addr_d  = add_i;
      end else begin
        rd_valid_d = 1'b1;
        rd_addr_d  = add_i;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (rd_valid_q && fill_empty) begin
          state_d = S_FETCH;
          n_d     = '0;
        end else if (wb_valid_q && wb_full) begin
          state_d = S_FLUSH;
          n_d     = '0;
        end
      end
      S_FETCH: begin
        // Low request for one cycle after every ack before the next word.
        if (!mem_req_q) begin
          if (!fill_full) begin
            mem_req_d = 1'b1;
            mem_rw_d  = 1'b0;
            mem_add_d = blk_add(rd_addr_q, n_q);
          end
        end else if (mem_ack_i) begin
          mem_req_d = 1'b0;
          n_d       = n_q + 1'b1;
          if (last) begin
            rd_valid_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_rw_d   = 1'b1;
          mem_add_d  = blk_add(wb_addr_q, n_q);
          mem_data_d = wb_mem_q[wb_rptr_q];
        end else if (mem_ack_i) begin
          mem_req_d = 1'b0;
          n_d       = n_q + 1'b1;
          if (last) begin
            wb_valid_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_req_d = ~rd_valid_d & ~wb_valid_d;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      ready_req_q <= 1'b1;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_add_q   <= '0;
      mem_data_q  <= '0;
      n_q         <= '0;
      wb_cnt_q    <= '0;
      wb_wptr_q   <= '0;
      wb_rptr_q   <= '0;
      fill_cnt_q  <= '0;
      fill_wptr_q <= '0;
      fill_rptr_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      ready_req_q <= ready_req_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_rw_q    <= mem_rw_d;
      mem_add_q   <= mem_add_d;
      mem_data_q  <= mem_data_d;
      n_q         <= n_d;
      wb_cnt_q    <= wb_cnt_d;
      wb_wptr_q   <= wb_wptr_d;
      wb_rptr_q   <= wb_rptr_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_wptr_q <= fill_wptr_d;
      fill_rptr_q <= fill_rptr_d;
    end
  end

  // Storage needs no reset: contents are only visible through the counts.
  always_ff @(posedge clock_i) begin
    if (wb_push) wb_mem_q[wb_wptr_q] <= data_i;
    if (fill_push) fill_mem_q[fill_wptr_q] <= mem_data_i;
  end

  assign ready_req_o   = ready_req_q;
  assign ready_write_o = ~wb_full;
  assign ready_read_o  = ~fill_empty;
  assign data_o        = fill_empty ? '0 : fill_mem_q[fill_rptr_q];
  assign err_o         = err_q;
  assign mem_req_o     = mem_req_q;
  assign mem_rw_o      = mem_rw_q;
  assign mem_add_o     = mem_add_q;
  assign mem_data_o    = mem_data_q;

`ifdef BLOCK_RESPONDER_PERF_EN
  logic [63:0] fetch_cnt_q, flush_cnt_q, stall_cnt_q;
  logic [31:0] comm_q, comm_d;
  logic        unused_comm;

  assign unused_comm = ^comm_i[31:4];

  always_comb begin
    comm_d = '0;
    case (comm_i[3:0])
      4'd0: comm_d = fetch_cnt_q[31:0];
      4'd1: comm_d = fetch_cnt_q[63:32];
      4'd2: comm_d = flush_cnt_q[31:0];
      4'd3: comm_d = flush_cnt_q[63:32];
      4'd4: comm_d = stall_cnt_q[31:0];
      4'd5: comm_d = stall_cnt_q[63:32];
      default: comm_d = '0;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
      comm_q      <= '0;
    end else begin
      if (fill_push && last) fetch_cnt_q <= fetch_cnt_q + 64'd1;
      if (wb_pop && last) flush_cnt_q <= flush_cnt_q + 64'd1;
      if (mem_req_q && !mem_ack_i) stall_cnt_q <= stall_cnt_q + 64'd1;
      comm_q <= comm_d;
    end
  end

  assign comm_o = comm_q;
`endif

endmodule

// File: tb/tb_cache_block_transfer_responder.sv
// Scoreboard bench for cache_block_transfer_responder.
// Expected memory and fill traffic is queued; a monitor checks it.
module tb_cache_block_transfer_responder;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        req_i = 1'b0;
  logic        req_block_i = 1'b1;
  logic        rw_i = 1'b0;
  logic [23:0] add_i = '0;
  logic        write_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        read_i = 1'b0;
  logic        ready_req_o, ready_write_o, ready_read_o;
  logic [31:0] data_o;
  logic        err_o;
  logic        mem_req_o, mem_rw_o;
  logic [23:0] mem_add_o;
  logic [31:0] mem_data_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = '0;
`ifdef BLOCK_RESPONDER_PERF_EN
  logic [31:0] comm_i = '0;
  logic [31:0] comm_o;
`endif

  always #5 clk = ~clk;

  cache_block_transfer_responder dut (
    .clock_i      (clk),
    .reset_i      (reset_i),
    .req_i        (req_i),
    .req_block_i  (req_block_i),
    .rw_i         (rw_i),
    .add_i        (add_i),
    .write_i      (write_i),
    .data_i       (data_i),
    .read_i       (read_i),
    .ready_req_o  (ready_req_o),
    .ready_write_o(ready_write_o),
    .ready_read_o (ready_read_o),
    .data_o       (data_o),
    .err_o        (err_o),
    .mem_req_o    (mem_req_o),
    .mem_rw_o     (mem_rw_o),
    .mem_add_o    (mem_add_o),
    .mem_data_o   (mem_data_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i)
`ifdef BLOCK_RESPONDER_PERF_EN
    ,
    .comm_i       (comm_i),
    .comm_o       (comm_o)
`endif
  );

  typedef struct packed {
    logic        rw;
    logic [23:0] add;
    logic [31:0] data;
  } mtx_t;

  mtx_t        exp_mem[$];
  logic [31:0] exp_fill[$];
  int n_tests = 0;
  int n_fail = 0;
  int req_cycles = 0;
  int ack_dly = 0;
  int wcnt = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wdata(input logic [23:0] a);
    return 32'hC000_0000 | {8'h00, a};
  endfunction

  // Memory model: acks ack_dly cycles after each request, data = address.
  always @(posedge clk) begin
    #1;
    if (!mem_req_o || mem_ack_i) begin
      mem_ack_i = 1'b0;
      wcnt = 0;
    end else if (wcnt >= ack_dly) begin
      mem_ack_i = 1'b1;
      mem_data_i = {8'h00, mem_add_o};
    end else begin
      wcnt++;
    end
  end

  // Monitor: checks each completed memory word and each cache pop.
  always @(negedge clk) begin
    mtx_t e;
    logic [31:0] f;
    if (mem_req_o) req_cycles++;
    if (mem_req_o && mem_ack_i) begin
      if (exp_mem.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mem_unexpected: got rw=%0b add=%0h expected none",
                 mem_rw_o, mem_add_o);
      end else begin
        e = exp_mem.pop_front();
        check("mem_rw", 64'(mem_rw_o), 64'(e.rw));
        check("mem_add", 64'(mem_add_o), 64'(e.add));
        if (e.rw) check("mem_data", 64'(mem_data_o), 64'(e.data));
      end
    end
    if (read_i && ready_read_o) begin
      if (exp_fill.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL fill_unexpected: got %0h expected none", data_o);
      end else begin
        f = exp_fill.pop_front();
        check("fill_data", 64'(data_o), 64'(f));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b1;
  endtask

  task automatic send_req(input logic rw, input logic [23:0] a,
                          input logic blk);
    req_i = 1'b1;
    rw_i = rw;
    add_i = a;
    req_block_i = blk;
    tick();
    req_i = 1'b0;
    req_block_i = 1'b1;
  endtask

  task automatic wr_word(input logic [31:0] d);
    write_i = 1'b1;
    data_i = d;
    tick();
    write_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (!ready_req_o && k < 3000) begin
      tick();
      k++;
    end
    check(nm, 64'(ready_req_o), 64'd1);
  endtask

  task automatic drain(input logic [23:0] base);
    int k;
    for (int i = 0; i < 16; i++) begin
      exp_fill.push_back({8'h00, base + 24'(i)});
      k = 0;
      while (!ready_read_o && k < 500) begin
        tick();
        k++;
      end
      if (k >= 500) check("drain_timeout", 64'(ready_read_o), 64'd1);
      read_i = 1'b1;
      tick();
      read_i = 1'b0;
    end
  endtask

  task automatic push_fetch(input logic [23:0] base);
    for (int i = 0; i < 16; i++)
      exp_mem.push_back({1'b0, base + 24'(i), 32'h0});
  endtask

  task automatic push_flush(input logic [23:0] base);
    for (int i = 0; i < 16; i++)
      exp_mem.push_back({1'b1, base + 24'(i), wdata(base + 24'(i))});
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_ready_req"}, 64'(ready_req_o), 64'd1);
    check({nm, "_ready_write"}, 64'(ready_write_o), 64'd1);
    check({nm, "_ready_read"}, 64'(ready_read_o), 64'd0);
    check({nm, "_err"}, 64'(err_o), 64'd0);
    check({nm, "_mem_req"}, 64'(mem_req_o), 64'd0);
    check({nm, "_mem_rw"}, 64'(mem_rw_o), 64'd0);
    check({nm, "_mem_add"}, 64'(mem_add_o), 64'd0);
    check({nm, "_mem_data"}, 64'(mem_data_o), 64'd0);
    check({nm, "_data"}, 64'(data_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    tick();
    tick();
    check_reset_vals("rst");
    reset_i = 1'b1;

    // Fetch 0x120 with two-cycle request latency.
    push_fetch(24'h120);
    send_req(1'b0, 24'h120, 1'b1);
    check("lat_ready_req_fall", 64'(ready_req_o), 64'd0);
    check("lat_c0", 64'(mem_req_o), 64'd0);
    tick();
    check("lat_c1", 64'(mem_req_o), 64'd0);
    tick();
    check("lat_c2", 64'(mem_req_o), 64'd1);
    wait_idle("fetch1_idle");
    check("fetch1_ready_read", 64'(ready_read_o), 64'd1);
    drain(24'h120);
    check("fetch1_empty", 64'(ready_read_o), 64'd0);
    check("fetch1_exp_mem", 64'(exp_mem.size()), 64'd0);

    // Writeback waits for the full block.
    for (int i = 0; i < 5; i++) wr_word(wdata(24'h340 + 24'(i)));
    send_req(1'b1, 24'h340, 1'b1);
    req_cycles = 0;
    repeat (30) tick();
    check("wb_partial_no_req", 64'(req_cycles), 64'd0);
    push_flush(24'h340);
    for (int i = 5; i < 16; i++) wr_word(wdata(24'h340 + 24'(i)));
    wait_idle("wb_idle");
    check("wb_exp_mem", 64'(exp_mem.size()), 64'd0);
    check("wb_ready_write", 64'(ready_write_o), 64'd1);

    // Fetch with writeback data streamed concurrently, then writeback.
    push_fetch(24'h500);
    send_req(1'b0, 24'h500, 1'b1);
    for (int i = 0; i < 16; i++) wr_word(wdata(24'h880 + 24'(i)));
    wait_idle("mix_fetch_idle");
    push_flush(24'h880);
    send_req(1'b1, 24'h880, 1'b1);
    wait_idle("mix_wb_idle");
    drain(24'h500);
    check("mix_exp_mem", 64'(exp_mem.size()), 64'd0);
    check("mix_err", 64'(err_o), 64'd0);

    // req_block_i == 0.
    do_reset();
    check("blk_err0", 64'(err_o), 64'd0);
    send_req(1'b0, 24'h900, 1'b0);
    check("blk_err", 64'(err_o), 64'd1);
    check("blk_ready_req", 64'(ready_req_o), 64'd1);
    repeat (20) tick();
    check("blk_no_req", 64'(mem_req_o), 64'd0);
    check("blk_err_sticky", 64'(err_o), 64'd1);

    // req while busy is ignored.
    do_reset();
    for (int i = 0; i < 16; i++) wr_word(wdata(24'hA00 + 24'(i)));
    push_flush(24'hA00);
    send_req(1'b1, 24'hA00, 1'b1);
    send_req(1'b0, 24'hB00, 1'b1);
    check("busy_err", 64'(err_o), 64'd1);
    wait_idle("busy_idle");
    repeat (10) tick();
    check("busy_exp_mem", 64'(exp_mem.size()), 64'd0);
    check("busy_ready_req", 64'(ready_req_o), 64'd1);

    // write_i while full drops the word.
    do_reset();
    for (int i = 0; i < 16; i++) wr_word(wdata(24'hC00 + 24'(i)));
    check("full_ready_write", 64'(ready_write_o), 64'd0);
    check("full_err0", 64'(err_o), 64'd0);
    wr_word(32'hDEAD_BEEF);
    check("full_err", 64'(err_o), 64'd1);
    push_flush(24'hC00);
    send_req(1'b1, 24'hC00, 1'b1);
    wait_idle("full_idle");
    check("full_exp_mem", 64'(exp_mem.size()), 64'd0);

    // read_i while empty.
    do_reset();
    read_i = 1'b1;
    tick();
    read_i = 1'b0;
    check("empty_err", 64'(err_o), 64'd1);
    check("empty_ready_read", 64'(ready_read_o), 64'd0);

    // Reset in the middle of a fetch at word 7.
    do_reset();
    push_fetch(24'h700);
    send_req(1'b0, 24'h700, 1'b1);
    k = 0;
    while (!(mem_req_o && mem_add_o == 24'h707) && k < 500) begin
      tick();
      k++;
    end
    check("midrst_reach_w7", 64'(mem_add_o), 64'h707);
    reset_i = 1'b0;
    tick();
    check_reset_vals("midrst");
    exp_mem.delete();
    reset_i = 1'b1;
    push_fetch(24'h720);
    send_req(1'b0, 24'h720, 1'b1);
    wait_idle("midrst_idle");
    drain(24'h720);
    check("midrst_exp_mem", 64'(exp_mem.size()), 64'd0);

`ifdef BLOCK_RESPONDER_PERF_EN
    do_reset();
    ack_dly = 3;
    push_fetch(24'h1000);
    send_req(1'b0, 24'h1000, 1'b1);
    wait_idle("perf_f1");
    drain(24'h1000);
    push_fetch(24'h1010);
    send_req(1'b0, 24'h1010, 1'b1);
    wait_idle("perf_f2");
    drain(24'h1010);
    for (int i = 0; i < 16; i++) wr_word(wdata(24'h2000 + 24'(i)));
    push_flush(24'h2000);
    send_req(1'b1, 24'h2000, 1'b1);
    wait_idle("perf_wb");
    comm_i = 32'd0;
    tick();
    check("perf_fetch", 64'(comm_o), 64'd2);
    comm_i = 32'd1;
    tick();
    check("perf_fetch_hi", 64'(comm_o), 64'd0);
    comm_i = 32'd2;
    tick();
    check("perf_flush", 64'(comm_o), 64'd1);
    comm_i = 32'd4;
    tick();
    check("perf_stall", 64'(comm_o), 64'd144);
    comm_i = 32'd7;
    tick();
    check("perf_other", 64'(comm_o), 64'd0);
    ack_dly = 0;
`endif

    check("end_exp_fill", 64'(exp_fill.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
